// File: rtl/rggen_bit_field_initiator.sv
// Host-side initiator for a single rggen bit field: accepts one request, issues a
// one-cycle access strobe, optionally waits, then holds the response until taken.
module rggen_bit_field_initiator #(
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_write,
    input  logic [WIDTH-1:0] i_req_strobe,
    input  logic [WIDTH-1:0] i_req_write_data,
    output logic             o_read_valid,
    output logic             o_write_valid,
    output logic [WIDTH-1:0] o_mask,
    output logic [WIDTH-1:0] o_write_data,
    input  logic [WIDTH-1:0] i_read_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_read_data,
    output logic [1:0]       o_rsp_status,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        WAIT     = 2'd2,
        RESPONSE = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       write_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            wait_cnt        <= 4'd0;
            write_q         <= 1'b0;
            o_req_ready     <= 1'b1;
            o_read_valid    <= 1'b0;
            o_write_valid   <= 1'b0;
            o_mask          <= '0;
            o_write_data    <= '0;
            o_rsp_valid     <= 1'b0;
            o_rsp_read_data <= '0;
            o_rsp_status    <= 2'b00;
            o_busy          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        state         <= ACCESS;
                        write_q       <= i_req_write;
                        o_req_ready   <= 1'b0;
                        o_busy        <= 1'b1;
                        o_mask        <= i_req_strobe;
                        o_write_data  <= i_req_write_data;
                        o_write_valid <= i_req_write && (i_req_strobe != '0);
                        o_read_valid  <= !i_req_write && (i_req_strobe != '0);
                    end
                end
                ACCESS: begin
                    // Sample read data on this edge, before any read side effect lands.
                    o_rsp_read_data <= (!write_q && (o_mask != '0)) ? (i_read_data & o_mask) : '0;
                    o_rsp_status    <= (o_mask == '0) ? 2'b01 : 2'b00;
                    o_read_valid    <= 1'b0;
                    o_write_valid   <= 1'b0;
                    o_mask          <= '0;
                    o_write_data    <= '0;
                    if (WAIT_CYCLES > 0) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state       <= RESPONSE;
                        o_rsp_valid <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= RESPONSE;
                        o_rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rggen_bit_field_initiator.md
RGGEN_BIT_FIELD_INITIATOR -- requirements
Module: rggen_bit_field_initiator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit-field data, mask and strobe width (1..64).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: idle cycles between the access cycle and the response (0..15).
REQ-003 SHALL have one clock, i_clk, and one synchronous active-high reset, i_rst; all state changes occur on rising i_clk.
REQ-004 i_clk  input  1  clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_req_valid  input  1  host request valid.
REQ-007 o_req_ready  output  1  request accepted when both req signals are high.
REQ-008 i_req_write  input  1  1 = write, 0 = read.
REQ-009 i_req_strobe  input  WIDTH  per-bit access enable.
REQ-010 i_req_write_data  input  WIDTH  write payload.
REQ-011 o_read_valid  output  1  read strobe to bit field.
REQ-012 o_write_valid  output  1  write strobe to bit field.
REQ-013 o_mask  output  WIDTH  access mask to bit field.
REQ-014 o_write_data  output  WIDTH  write data to bit field.
REQ-015 i_read_data  input  WIDTH  combinational read data from bit field.
REQ-016 o_rsp_valid  output  1  response valid.
REQ-017 i_rsp_ready  input  1  host accepts response.
REQ-018 o_rsp_read_data  output  WIDTH  captured read data; 0 for writes.
REQ-019 o_rsp_status  output  2  00 = OK, 01 = no-op (zero strobe).
REQ-020 o_busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement the FSM IDLE, ACCESS, WAIT, RESPONSE.
REQ-022 o_req_ready SHALL equal 1 only in IDLE.
REQ-023 IDLE: on i_req_valid && o_req_ready, register write, strobe and write data; go to ACCESS.
REQ-024 ACCESS lasts exactly one cycle.
  - o_mask = registered strobe; o_write_data = registered data.
  - If strobe != 0: o_write_valid = write, o_read_valid = !write.
  - If strobe == 0: both valids 0 and status = 01.
REQ-025 Outside ACCESS, o_read_valid, o_write_valid, o_mask and o_write_data SHALL be 0.
REQ-026 Reads: i_read_data & mask SHALL be captured at the rising edge that ends ACCESS, before any clear-on-read or set-on-read update becomes visible.
REQ-027 Writes and no-ops SHALL return o_rsp_read_data = 0.
REQ-028 From ACCESS, go to WAIT when WAIT_CYCLES > 0, otherwise go directly to RESPONSE.
REQ-029 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to RESPONSE.
REQ-030 Latency: a request accepted at edge T SHALL have ACCESS in cycle T+1 and o_rsp_valid first high in cycle T+2+WAIT_CYCLES.
REQ-031 RESPONSE: o_rsp_valid = 1; o_rsp_read_data and o_rsp_status SHALL stay stable until i_rsp_ready.
REQ-032 On i_rsp_ready in RESPONSE, return to IDLE; o_req_ready SHALL be 1 in the following cycle. Minimum back-to-back period is 3+WAIT_CYCLES cycles.
REQ-033 Request inputs SHALL be ignored outside IDLE; no request is queued.
REQ-034 o_rsp_valid SHALL be 0 outside RESPONSE; o_rsp_read_data and o_rsp_status hold their last values.
REQ-035 Exactly one bit-field strobe pulse SHALL be issued per accepted request with nonzero strobe, and none otherwise.

Reset
REQ-036 While i_rst is high at a rising edge, the FSM SHALL go to IDLE, the counter to 0 and all registered data/status to 0.
REQ-037 After reset, outputs SHALL be: o_req_ready = 1; every other output = 0.
REQ-038 Reset asserted in ACCESS, WAIT or RESPONSE SHALL:
  - drop all strobes from the next cycle;
  - discard any pending response;
  - issue no further bit-field access.

Verification
REQ-039 WIDTH=8, WAIT=0: read, strobe FF, i_read_data=A5 -> o_read_valid one cycle at T+1; rsp data A5, status 00, rsp_valid at T+2.
REQ-040 Write, strobe 0F, data 3C -> o_write_valid one cycle with mask 0F, data 3C; rsp data 00, status 00.
REQ-041 Strobe 00 -> no strobe pulse; rsp status 01, data 00.
REQ-042 Clear-on-read model: read_data=5A in ACCESS, 00 afterwards -> rsp data 5A; read_data & mask=F0 captured as 50.
REQ-043 WAIT=3, i_rsp_ready held low 4 cycles -> rsp_valid first at T+5; data stable until ready; req_ready low until the cycle after acceptance.
REQ-044 Reset during WAIT -> next cycle: o_busy=0, o_rsp_valid=0, o_req_ready=1, no strobe pulse.
